// File: rtl/minitb_checker.sv
// minitb package and minitb_checker: a scoreboard that queues expected beats
// taken from a DUT's input stream and compares them, in order, against the
// beats seen on the DUT's output stream. Matches and mismatches are counted.
// Underflow, overflow, mismatch and head-of-queue timeout are recorded as
// sticky error flags.

package minitb;
    localparam int BusWidth = 8;
endpackage : minitb

module minitb_checker #(
    parameter int Depth   = 4,
    parameter int Timeout = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          exp_valid,
    input  logic [minitb::BusWidth-1:0]   exp_data,
    input  logic                          act_valid,
    input  logic [minitb::BusWidth-1:0]   act_data,
    input  logic                          clear,
    output logic [15:0]                   match_count,
    output logic [15:0]                   mismatch_count,
    output logic [3:0]                    err_flags,
    output logic [$clog2(Depth):0]        level,
    output logic                          busy
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;
    localparam int AgeW = $clog2(Timeout + 1);

    localparam logic [LvlW-1:0] FullLevel   = LvlW'(Depth);
    localparam logic [AgeW-1:0] TimeoutAge  = AgeW'(Timeout);

    // Expected-entry storage and its bookkeeping.
    logic [minitb::BusWidth-1:0] mem_r [Depth];
    logic [PtrW-1:0]             wr_ptr_r;
    logic [PtrW-1:0]             rd_ptr_r;
    logic [LvlW-1:0]             level_r;
    logic [AgeW-1:0]             age_r;
    logic [15:0]                 match_r;
    logic [15:0]                 mismatch_r;
    logic [3:0]                  flags_r;
    logic                        busy_r;

    // Per-cycle event decode.
    logic                        full_s;
    logic                        empty_s;
    logic                        pop_s;
    logic                        push_s;
    logic                        underflow_s;
    logic                        overflow_s;
    logic                        hit_s;
    logic                        timeout_s;
    logic [LvlW-1:0]             level_next_s;
    logic [AgeW-1:0]             age_next_s;

    // Decode push/pop/error events and the next occupancy and head age.
    always_comb begin
        full_s       = 1'b0;
        empty_s      = 1'b0;
        pop_s        = 1'b0;
        push_s       = 1'b0;
        underflow_s  = 1'b0;
        overflow_s   = 1'b0;
        hit_s        = 1'b0;
        timeout_s    = 1'b0;
        level_next_s = level_r;
        age_next_s   = age_r;

        full_s      = (level_r == FullLevel);
        empty_s     = (level_r == {LvlW{1'b0}});
        // A beat arriving on an empty queue is never compared against the
        // entry pushed in the same cycle.
        pop_s       = act_valid && !empty_s;
        underflow_s = act_valid && empty_s;
        // When full, a coinciding pop frees the slot the push needs.
        push_s      = exp_valid && (!full_s || pop_s);
        overflow_s  = exp_valid && full_s && !pop_s;
        // Case equality so that X/Z on act_data counts as a mismatch.
        hit_s       = (mem_r[rd_ptr_r] === act_data);

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + {{(LvlW-1){1'b0}}, 1'b1};
            2'b01:   level_next_s = level_r - {{(LvlW-1){1'b0}}, 1'b1};
            default: level_next_s = level_r;
        endcase

        if (pop_s || (level_next_s == {LvlW{1'b0}})) begin
            age_next_s = {AgeW{1'b0}};
        end else if (age_r < TimeoutAge) begin
            age_next_s = age_r + {{(AgeW-1){1'b0}}, 1'b1};
        end else begin
            age_next_s = age_r;
        end

        timeout_s = (age_next_s == TimeoutAge);
    end

    // Write pushed expected beats into storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {minitb::BusWidth{1'b0}};
            end
        end else if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= exp_data;
        end
    end

    // Pointers, occupancy and head age; clear empties the queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            level_r  <= {LvlW{1'b0}};
            age_r    <= {AgeW{1'b0}};
            busy_r   <= 1'b0;
        end else if (clear) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            level_r  <= {LvlW{1'b0}};
            age_r    <= {AgeW{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PtrW-1){1'b0}}, 1'b1};
            end
            level_r <= level_next_s;
            age_r   <= age_next_s;
            busy_r  <= (level_next_s != {LvlW{1'b0}});
        end
    end

    // Saturating match/mismatch counters and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_r    <= 16'h0000;
            mismatch_r <= 16'h0000;
            flags_r    <= 4'b0000;
        end else if (clear) begin
            match_r    <= 16'h0000;
            mismatch_r <= 16'h0000;
            flags_r    <= 4'b0000;
        end else begin
            if (pop_s && hit_s && (match_r != 16'hFFFF)) begin
                match_r <= match_r + 16'h0001;
            end
            if (pop_s && !hit_s && (mismatch_r != 16'hFFFF)) begin
                mismatch_r <= mismatch_r + 16'h0001;
            end
            flags_r <= flags_r | {timeout_s, overflow_s, underflow_s, (pop_s && !hit_s)};
        end
    end

    assign match_count    = match_r;
    assign mismatch_count = mismatch_r;
    assign err_flags      = flags_r;
    assign level          = level_r;
    assign busy           = busy_r;

endmodule : minitb_checker

// File: tb/tb_minitb_checker.sv
// Self-checking bench for minitb_checker: directed scenarios plus a random
// run checked against a queue-based reference model.

module tb_minitb_checker;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exp_valid = 1'b0;
    logic [7:0]  exp_data = 8'h00;
    logic        act_valid = 1'b0;
    logic [7:0]  act_data = 8'h00;
    logic        clear = 1'b0;
    logic [15:0] match_count;
    logic [15:0] mismatch_count;
    logic [3:0]  err_flags;
    logic [2:0]  level;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] q [$];
    int         m_match = 0;
    int         m_mis   = 0;
    logic [3:0] m_flags = 4'b0000;
    int         m_age   = 0;

    minitb_checker #(.Depth(DEPTH), .Timeout(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .exp_valid      (exp_valid),
        .exp_data       (exp_data),
        .act_valid      (act_valid),
        .act_data       (act_data),
        .clear          (clear),
        .match_count    (match_count),
        .mismatch_count (mismatch_count),
        .err_flags      (err_flags),
        .level          (level),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_match = 0;
        m_mis   = 0;
        m_flags = 4'b0000;
        m_age   = 0;
    endtask

    // Apply one cycle of inputs, advance the model, settle just after the edge.
    task automatic tick(input logic ev, input logic [7:0] ed,
                        input logic av, input logic [7:0] ad, input logic clr);
        logic       popped;
        logic [7:0] head;
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; clear = clr;
        @(posedge clk);
        n_vec++;
        popped = 1'b0;
        if (clr) begin
            model_clear();
        end else begin
            if (av) begin
                if (q.size() == 0) begin
                    m_flags[1] = 1'b1;
                end else begin
                    head = q.pop_front();
                    popped = 1'b1;
                    if (head === ad) begin
                        if (m_match < 65535) m_match++;
                    end else begin
                        if (m_mis < 65535) m_mis++;
                        m_flags[0] = 1'b1;
                    end
                end
            end
            if (ev) begin
                if (q.size() < DEPTH) q.push_back(ed);
                else m_flags[2] = 1'b1;
            end
            if (popped || q.size() == 0) m_age = 0;
            else if (m_age < TIMEOUT) m_age++;
            if (q.size() != 0 && m_age == TIMEOUT) m_flags[3] = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_valid = 1'b0; act_valid = 1'b0; clear = 1'b0;
        #1;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({level, busy, err_flags} !== 8'h00) begin
            n_err++; $display("FAIL reset_state: level/busy/flags got %0h expected 0", {level, busy, err_flags});
        end
        if ({match_count, mismatch_count} !== 32'h0) begin
            n_err++; $display("FAIL reset_counts: got %0h expected 0", {match_count, mismatch_count});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_match();
        do_reset();
        tick(1'b1, 8'd10, 1'b0, 8'd0, 1'b0);
        tick(1'b1, 8'd20, 1'b0, 8'd0, 1'b0);
        tick(1'b1, 8'd30, 1'b1, 8'd10, 1'b0);
        if (level !== 3'd2) begin
            n_err++; $display("FAIL match_mid_level: got %0d expected 2", level);
        end
        tick(1'b0, 8'd0, 1'b1, 8'd20, 1'b0);
        tick(1'b0, 8'd0, 1'b1, 8'd30, 1'b0);
        if (match_count !== 16'd3) begin
            n_err++; $display("FAIL match_count: got %0d expected 3", match_count);
        end
        if (mismatch_count !== 16'd0 || err_flags !== 4'b0000) begin
            n_err++; $display("FAIL match_clean: mis %0d flags %b expected 0 0000", mismatch_count, err_flags);
        end
        if (level !== 3'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL match_level: level %0d busy %b expected 0 0", level, busy);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        tick(1'b1, 8'd5, 1'b0, 8'd0, 1'b0);
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mismatch_busy: got %b expected 1", busy);
        end
        tick(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        tick(1'b0, 8'd0, 1'b1, 8'd6, 1'b0);
        if (mismatch_count !== 16'd1 || match_count !== 16'd0) begin
            n_err++; $display("FAIL mismatch_count: mis %0d match %0d expected 1 0", mismatch_count, match_count);
        end
        if (err_flags !== 4'b0001 || level !== 3'd0) begin
            n_err++; $display("FAIL mismatch_flags: flags %b level %0d expected 0001 0", err_flags, level);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        tick(1'b1, 8'h33, 1'b1, 8'h33, 1'b0);
        if (err_flags !== 4'b0010 || level !== 3'd1) begin
            n_err++; $display("FAIL underflow: flags %b level %0d expected 0010 1", err_flags, level);
        end
        if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin
            n_err++; $display("FAIL underflow_counts: match %0d mis %0d expected 0 0", match_count, mismatch_count);
        end
    endtask

    task automatic test_overflow_timeout();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0);
        if (level !== 3'd4 || err_flags !== 4'b0000) begin
            n_err++; $display("FAIL fill: level %0d flags %b expected 4 0000", level, err_flags);
        end
        tick(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        if (level !== 3'd4 || err_flags !== 4'b0100) begin
            n_err++; $display("FAIL overflow: level %0d flags %b expected 4 0100", level, err_flags);
        end
        idle(2);
        if (err_flags[3] !== 1'b0) begin
            n_err++; $display("FAIL timeout_early: flag %b expected 0", err_flags[3]);
        end
        idle(TIMEOUT);
        if (err_flags !== 4'b1100 || level !== 3'd4) begin
            n_err++; $display("FAIL timeout: flags %b level %0d expected 1100 4", err_flags, level);
        end
        // Head is kept after a timeout and still compares.
        tick(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
        if (match_count !== 16'd1) begin
            n_err++; $display("FAIL timeout_head_kept: match %0d expected 1", match_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'(8'h80 + i), 1'b1, 8'(8'h40 + i), 1'b0);
            if (level !== 3'd4) begin
                n_err++; $display("FAIL full_pushpop_level: got %0d expected 4", level);
            end
        end
        if (match_count !== 16'd3 || err_flags !== 4'b0000) begin
            n_err++; $display("FAIL full_pushpop: match %0d flags %b expected 3 0000", match_count, err_flags);
        end
    endtask

    task automatic test_clear();
        do_reset();
        tick(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 8'h12, 1'b0);
        tick(1'b1, 8'h13, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h99, 1'b1, 8'h00, 1'b1);
        if ({level, busy, err_flags} !== 8'h00 || {match_count, mismatch_count} !== 32'h0) begin
            n_err++; $display("FAIL clear: level %0d flags %b match %0d mis %0d expected all 0",
                              level, err_flags, match_count, mismatch_count);
        end
        tick(1'b1, 8'h07, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 8'h07, 1'b0);
        if (match_count !== 16'd1 || err_flags !== 4'b0000 || level !== 3'd0) begin
            n_err++; $display("FAIL after_clear: match %0d flags %b level %0d expected 1 0000 0",
                              match_count, err_flags, level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1'b1, 8'h21, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h22, 1'b1, 8'h00, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({level, busy, err_flags} !== 8'h00 || {match_count, mismatch_count} !== 32'h0) begin
            n_err++; $display("FAIL reset_mid: level %0d flags %b match %0d mis %0d expected all 0",
                              level, err_flags, match_count, mismatch_count);
        end
        exp_valid = 1'b0; act_valid = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1, 8'h09, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 8'h09, 1'b0);
        if (match_count !== 16'd1 || err_flags !== 4'b0000 || level !== 3'd0) begin
            n_err++; $display("FAIL after_reset: match %0d flags %b level %0d expected 1 0000 0",
                              match_count, err_flags, level);
        end
    endtask

    task automatic test_random();
        logic       ev, av, clr;
        logic [7:0] ed, ad;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ev  = ($urandom_range(0, 1) == 1);
            av  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 79) == 0);
            ed  = 8'($urandom_range(0, 255));
            if (q.size() > 0 && $urandom_range(0, 3) != 0) ad = q[0];
            else ad = 8'($urandom_range(0, 255));
            tick(ev, ed, av, ad, clr);
            if (level !== 3'(q.size()) || busy !== (q.size() != 0)) begin
                n_err++; $display("FAIL rnd_level: level %0d busy %b expected %0d", level, busy, q.size());
            end
            if (match_count !== 16'(m_match) || mismatch_count !== 16'(m_mis)) begin
                n_err++; $display("FAIL rnd_counts: match %0d mis %0d expected %0d %0d",
                                  match_count, mismatch_count, m_match, m_mis);
            end
            if (err_flags !== m_flags) begin
                n_err++; $display("FAIL rnd_flags: got %b expected %b", err_flags, m_flags);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_underflow();
        test_overflow_timeout();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_minitb_checker

// File: doc/minitb_checker.md
MINITB_CHECKER -- requirements
Module: minitb_checker

Interface
REQ-001 The parameter set SHALL be `Depth`, default 4, expected-entry FIFO depth, power of two, at least 2.
REQ-002 The parameter set SHALL include `Timeout`, default 8, the maximum cycles the FIFO head may wait for a matching output, at least 1.
REQ-003 Data width SHALL be `minitb::BusWidth`, taken from the minitb package; it is not a local parameter.
REQ-004 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-005 Port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 Port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port `exp_valid`, input, 1 bit: the DUT-input stream (valid_in) is sampled here.
REQ-008 Port `exp_data`, input, BusWidth bits: the DUT-input data (data_in).
REQ-009 Port `act_valid`, input, 1 bit: the DUT-output stream (valid_out) is sampled here.
REQ-010 Port `act_data`, input, BusWidth bits: the DUT-output data (data_out).
REQ-011 Port `clear`, input, 1 bit: synchronous clear of FIFO, counters and flags.
REQ-012 Port `match_count`, output, 16 bits: count of compared beats that matched.
REQ-013 Port `mismatch_count`, output, 16 bits: count of compared beats that mismatched.
REQ-014 Port `err_flags`, output, 4 bits, sticky: [0] mismatch, [1] underflow, [2] overflow, [3] timeout.
REQ-015 Port `level`, output, $clog2(Depth)+1 bits: current FIFO occupancy.
REQ-016 Port `busy`, output, 1 bit: asserted exactly when `level` is non-zero.

Function
REQ-017 When `exp_valid` is 1 and the FIFO is not full, `exp_data` SHALL be pushed at the clock edge.
REQ-018 When `act_valid` is 1 and the FIFO is not empty, the head SHALL be popped and compared with `act_data` in the same cycle.
REQ-019 An equal comparison SHALL increment `match_count`; an unequal one SHALL increment `mismatch_count` and set err_flags[0].
REQ-020 When `act_valid` is 1 and the FIFO is empty, the block SHALL set err_flags[1] and change no counter; a same-cycle push SHALL still occur, and the act beat SHALL never be compared against it.
REQ-021 When `exp_valid` is 1, the FIFO is full and no pop occurs, the beat SHALL be dropped and err_flags[2] set.
REQ-022 When the FIFO is full and a push and a pop coincide, both SHALL occur, `level` SHALL stay unchanged, and no overflow SHALL be flagged.
REQ-023 The FIFO SHALL use read and write pointers that wrap modulo Depth; `level` SHALL update by +1 on push only, -1 on pop only, and 0 on both or neither.
REQ-024 Age counter: reset to 0 on any pop or whenever the FIFO is empty after the edge; otherwise it SHALL increment once per cycle and saturate at Timeout.
REQ-025 When the age counter reaches Timeout, err_flags[3] SHALL be set; the head entry SHALL be kept, not dropped.
REQ-026 `match_count` and `mismatch_count` SHALL saturate at 16'hFFFF and never wrap.
REQ-027 `err_flags` bits SHALL be set-only and cleared solely by reset or `clear`.
REQ-028 When `clear` is 1, the block SHALL empty the FIFO and zero the counters, flags and age counter; all push, pop and error events in that cycle SHALL be ignored.
REQ-029 Every output SHALL be driven from a register, with no combinational path from input to output; counters and flags SHALL reflect an event on the cycle after it.
REQ-030 Comparison SHALL be bitwise equality over the full BusWidth, and X/Z on act_data SHALL count as mismatch.

Reset
REQ-031 Asserting `reset_n` low SHALL immediately force `level`=0, `busy`=0, both counters=0, `err_flags`=4'b0000, the age counter=0 and both pointers=0.
REQ-032 Reset asserted mid-operation SHALL discard all FIFO contents, with no error flagged for lost entries.
REQ-033 After `reset_n` deasserts, the first edge SHALL sample inputs normally.

Verification
REQ-034 The bench SHALL drive exp 10,20,30 on consecutive cycles and act the same values two cycles later -> match_count=3, mismatch_count=0, err_flags=0, level returns to 0.
REQ-035 The bench SHALL drive exp 5 and then act 6 two cycles later -> mismatch_count=1, err_flags=4'b0001, level=0.
REQ-036 The bench SHALL drive act_valid with an empty FIFO and exp_valid in the same cycle -> err_flags=4'b0010, level=1, both counters 0.
REQ-037 The bench SHALL push 4 beats with Depth=4 and no act, then push a fifth -> level=4, err_flags[2]=1; after Timeout cycles, err_flags[3]=1.
REQ-038 The bench SHALL fill the FIFO, then drive exp and a matching act together for 3 cycles -> level stays 4, no overflow, match_count=3.
REQ-039 The bench SHALL pulse `clear` after errors, and separately drop reset_n low mid-stream -> counters, flags and level all 0, and subsequent traffic is checked correctly.
